// File: rtl/pmem_arbiter.sv
// Arbiter between the I-cache and D-cache physical-memory ports and the single pmem.
// Grants one line transaction at a time, round-robin on contention, and counts contested grants.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_conflicts,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [15:0]           conflicts
);

    // state   | meaning
    // IDLE    | no grant; decides the next grant (also the turnaround cycle)
    // SERVE_I | I-cache transaction forwarded to pmem until pmem_resp
    // SERVE_D | D-cache transaction forwarded to pmem until pmem_resp
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state;
    logic   last_grant_d;
    logic   i_req;
    logic   d_req;
    logic   contested;

    assign i_req     = i_pmem_read | i_pmem_write;
    assign d_req     = d_pmem_read | d_pmem_write;
    assign contested = i_req & d_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            conflicts    <= '0;
        end else begin
            if (reset_conflicts)
                conflicts <= '0;
            else if (state == IDLE && contested && conflicts != 16'hFFFF)
                conflicts <= conflicts + 16'd1;

            case (state)
                IDLE: begin
                    if (contested) begin
                        // Round-robin: the client that did not win last time gets it now.
                        state        <= last_grant_d ? SERVE_I : SERVE_D;
                        last_grant_d <= ~last_grant_d;
                    end else if (i_req) begin
                        state        <= SERVE_I;
                        last_grant_d <= 1'b0;
                    end else if (d_req) begin
                        state        <= SERVE_D;
                        last_grant_d <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read+write asserted together is a write, so read is masked by write.
    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                pmem_write   = i_pmem_write;
                pmem_read    = i_pmem_read & ~i_pmem_write;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized clients and pmem,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_pmem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset, reset_conflicts;
    logic [AW-1:0] i_pmem_address, d_pmem_address, pmem_address;
    logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [LW-1:0] i_pmem_wdata, d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
    logic          i_pmem_resp, d_pmem_resp;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [LW-1:0] pmem_wdata, pmem_rdata;
    logic [15:0]   conflicts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .reset_conflicts(reset_conflicts),
        .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
        .i_pmem_write(i_pmem_write), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .conflicts(conflicts)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: who owns pmem (0 none, 1 I, 2 D), who won last, contested-grant count.
    int          m_owner = 0;
    int          m_last  = 1;
    int unsigned m_cnt   = 0;
    bit          m_valid = 0;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    logic          e_rd, e_wr, e_ir, e_dr, iq, dq;

    always @(negedge clk) begin
        if (m_valid) begin
            e_addr = '0; e_wd = '0; e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0;
            if (m_owner == 1) begin
                e_addr = i_pmem_address; e_wd = i_pmem_wdata;
                e_wr = i_pmem_write; e_rd = i_pmem_read && !i_pmem_write; e_ir = pmem_resp;
            end else if (m_owner == 2) begin
                e_addr = d_pmem_address; e_wd = d_pmem_wdata;
                e_wr = d_pmem_write; e_rd = d_pmem_read && !d_pmem_write; e_dr = pmem_resp;
            end
            chk("pmem_address", pmem_address, e_addr);
            chk("pmem_wdata", pmem_wdata, e_wd);
            chk("pmem_read", pmem_read, e_rd);
            chk("pmem_write", pmem_write, e_wr);
            chk("i_pmem_resp", i_pmem_resp, e_ir);
            chk("d_pmem_resp", d_pmem_resp, e_dr);
            chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
            chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
            chk("conflicts", conflicts, m_cnt[15:0]);
        end
        if (reset) begin
            m_owner = 0; m_last = 1; m_cnt = 0; m_valid = 1;
        end else if (m_valid) begin
            iq = i_pmem_read || i_pmem_write;
            dq = d_pmem_read || d_pmem_write;
            if (reset_conflicts) m_cnt = 0;
            else if (m_owner == 0 && iq && dq && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_owner != 0) begin
                if (pmem_resp) m_owner = 0;
            end else if (iq && dq) begin
                m_owner = (m_last == 1) ? 2 : 1;
                m_last  = m_owner;
            end else if (iq) begin
                m_owner = 1; m_last = 1;
            end else if (dq) begin
                m_owner = 2; m_last = 2;
            end
        end
    end

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    task automatic do_reset();
        nxt(); reset = 1;
        nxt(); reset = 0;
    endtask

    // Both clients keep requesting; pmem answers immediately in each serve cycle.
    task automatic run_contested(input int n, input bit first_d);
        bit d_turn = first_d;
        for (int k = 0; k < n; k++) begin
            nxt(); pmem_resp = 1;
            mid();
            chk("rr_address", pmem_address, d_turn ? d_pmem_address : i_pmem_address);
            chk("rr_d_resp", d_pmem_resp, d_turn);
            chk("rr_i_resp", i_pmem_resp, !d_turn);
            d_turn = !d_turn;
            nxt(); pmem_resp = 0;
        end
        i_pmem_read = 0; i_pmem_write = 0; d_pmem_read = 0; d_pmem_write = 0;
    endtask

    task automatic client_step(input bit seen, inout bit active, inout int gap,
                               inout logic rd, inout logic wr,
                               inout logic [AW-1:0] a, inout logic [LW-1:0] wd);
        int kind;
        if (active && seen) begin
            active = 0; rd = 0; wr = 0; gap = $urandom_range(0, 2);
        end else if (!active) begin
            a  = AW'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            if (gap > 0) gap--;
            else if ($urandom_range(0, 1) == 1) begin
                active = 1;
                kind = $urandom_range(0, 3);
                rd = (kind != 1);
                wr = (kind == 1 || kind == 2);
            end
        end
    endtask

    bit  i_act = 0, d_act = 0, i_seen = 0, d_seen = 0;
    int  i_gap = 0, d_gap = 0;

    initial begin
        reset = 1; reset_conflicts = 0;
        i_pmem_address = '0; i_pmem_read = 0; i_pmem_write = 0; i_pmem_wdata = '0;
        d_pmem_address = '0; d_pmem_read = 0; d_pmem_write = 0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        repeat (2) nxt();
        reset = 0;
        mid();
        chk("reset_conflicts_zero", conflicts, 16'h0);
        chk("reset_pmem_read", pmem_read, 1'b0);
        chk("reset_pmem_write", pmem_write, 1'b0);

        // D-cache read alone, answered on the third serve cycle
        nxt(); d_pmem_read = 1; d_pmem_address = 16'h0120;
        mid(); chk("d_only_decision", pmem_read, 1'b0);
        nxt(); mid();
        chk("d_only_strobe", pmem_read, 1'b1);
        chk("d_only_addr", pmem_address, 16'h0120);
        nxt();
        nxt(); pmem_resp = 1; pmem_rdata = 128'hCAFE_0001_0002_0003_0004_0005_0006_0007;
        mid();
        chk("d_only_resp", d_pmem_resp, 1'b1);
        chk("d_only_rdata", d_pmem_rdata, 128'hCAFE_0001_0002_0003_0004_0005_0006_0007);
        chk("d_only_i_resp", i_pmem_resp, 1'b0);
        nxt(); pmem_resp = 0; d_pmem_read = 0;
        mid(); chk("d_only_resp_one_cycle", d_pmem_resp, 1'b0);

        // I read and D write together right after reset: D first
        nxt(); reset = 1;
        nxt(); reset = 0;
        i_pmem_read = 1; i_pmem_address = 16'h1000;
        d_pmem_write = 1; d_pmem_address = 16'h2000; d_pmem_wdata = 128'h1234;
        nxt(); mid();
        chk("first_contest_write", pmem_write, 1'b1);
        chk("first_contest_addr", pmem_address, 16'h2000);
        chk("first_contest_wdata", pmem_wdata, 128'h1234);
        chk("first_contest_cnt", conflicts, 16'd1);
        nxt(); pmem_resp = 1;
        mid(); chk("first_contest_d_resp", d_pmem_resp, 1'b1);
        chk("first_contest_i_quiet", i_pmem_resp, 1'b0);
        nxt(); pmem_resp = 0; d_pmem_write = 0;
        mid(); chk("turnaround_idle", pmem_read, 1'b0);
        nxt(); mid();
        chk("i_after_d_read", pmem_read, 1'b1);
        chk("i_after_d_addr", pmem_address, 16'h1000);
        chk("i_after_d_cnt", conflicts, 16'd1);
        nxt(); pmem_resp = 1;
        mid(); chk("i_after_d_resp", i_pmem_resp, 1'b1);
        nxt(); pmem_resp = 0; i_pmem_read = 0;

        // Continuous contention for four transactions: D,I,D,I
        do_reset();
        i_pmem_read = 1; i_pmem_address = 16'h0A00;
        d_pmem_read = 1; d_pmem_address = 16'h0D00;
        run_contested(4, 1'b1);
        mid(); chk("four_contests", conflicts, 16'd4);

        // Reset while I is being served
        nxt(); i_pmem_read = 1; i_pmem_address = 16'h0300;
        nxt(); mid(); chk("abort_strobe_before", pmem_read, 1'b1);
        nxt(); reset = 1;
        mid(); chk("abort_no_resp", i_pmem_resp, 1'b0);
        nxt(); reset = 0; i_pmem_read = 0;
        mid();
        chk("abort_strobe_after", pmem_read, 1'b0);
        chk("abort_cnt", conflicts, 16'd0);
        chk("abort_i_resp", i_pmem_resp, 1'b0);

        // Spurious pmem_resp in IDLE, then a D request still needs its decision cycle
        nxt(); pmem_resp = 1;
        mid(); chk("spurious_i", i_pmem_resp, 1'b0); chk("spurious_d", d_pmem_resp, 1'b0);
        nxt(); pmem_resp = 0; d_pmem_read = 1; d_pmem_address = 16'h0444;
        mid(); chk("spurious_still_idle", pmem_read, 1'b0);
        nxt(); mid(); chk("spurious_then_grant", pmem_address, 16'h0444);
        nxt(); pmem_resp = 1;
        nxt(); pmem_resp = 0; d_pmem_read = 0;

        // Saturation from 16'hFFFE; D won last, so I wins the first contest
        mid();
        force dut.conflicts = 16'hFFFE;
        #1 release dut.conflicts;
        m_cnt = 16'hFFFE;
        nxt();
        i_pmem_read = 1; i_pmem_address = 16'h0B00;
        d_pmem_write = 1; d_pmem_address = 16'h0C00;
        run_contested(3, 1'b0);
        mid(); chk("saturated", conflicts, 16'hFFFF);

        // reset_conflicts beats the increment of a contested grant
        nxt(); i_pmem_read = 1; d_pmem_read = 1; reset_conflicts = 1;
        nxt(); reset_conflicts = 0;
        mid(); chk("clear_beats_incr", conflicts, 16'd0);
        nxt(); pmem_resp = 1;
        nxt(); pmem_resp = 0; i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            nxt();
            reset           = ($urandom_range(0, 299) == 0);
            reset_conflicts = ($urandom_range(0, 99) == 0);
            pmem_resp       = ($urandom_range(0, 2) == 0);
            pmem_rdata      = {$urandom, $urandom, $urandom, $urandom};
            client_step(i_seen, i_act, i_gap, i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata);
            client_step(d_seen, d_act, d_gap, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata);
            mid();
            i_seen = i_pmem_resp;
            d_seen = d_pmem_resp;
        end

        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches, between their physical-memory ports and the single physical memory.
- Grants one cache's line-fill or write-back transaction at a time and forwards it to pmem.
- Routes the pmem response back to the granted cache only.
- Counts arbitration conflicts for performance measurement, alongside the caches' hit/miss counters.

Parameters:
ADDR_WIDTH, 16, byte address width of pmem transactions
LINE_WIDTH, 128, cache line width in bits (16-byte line)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
reset_conflicts  in  1  synchronous clear of conflicts counter
i_pmem_address  in  ADDR_WIDTH  I-cache transaction address
i_pmem_read  in  1  I-cache line read request
i_pmem_write  in  1  I-cache line write request
i_pmem_wdata  in  LINE_WIDTH  I-cache write line
i_pmem_rdata  out  LINE_WIDTH  read line to I-cache
i_pmem_resp  out  1  I-cache transaction complete
d_pmem_address  in  ADDR_WIDTH  D-cache transaction address
d_pmem_read  in  1  D-cache line read request
d_pmem_write  in  1  D-cache line write request (dirty write-back)
d_pmem_wdata  in  LINE_WIDTH  D-cache write line
d_pmem_rdata  out  LINE_WIDTH  read line to D-cache
d_pmem_resp  out  1  D-cache transaction complete
pmem_address  out  ADDR_WIDTH  address to physical memory
pmem_read  out  1  read strobe to physical memory
pmem_write  out  1  write strobe to physical memory
pmem_wdata  out  LINE_WIDTH  write line to physical memory
pmem_rdata  in  LINE_WIDTH  read line from physical memory
pmem_resp  in  1  physical memory done
conflicts  out  16  saturating count of contested grants

Behaviour:
- Client request: x_req = x_pmem_read | x_pmem_write.
  - Clients hold read/write, address and wdata stable until they see x_pmem_resp.
  - If a client asserts read and write together, it is treated as a write.
- States:
  - IDLE: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, both resps 0.
  - SERVE_I: pmem_address, pmem_wdata and read/write strobes are driven combinationally from the I-cache inputs.
  - SERVE_D: same, from the D-cache inputs.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only one client requesting: go to that client's SERVE state.
  - Both requesting: grant the client not equal to last_grant (round-robin), so a continuous requester cannot starve the other.
  - last_grant resets to I, so D wins the first contested arbitration.
  - last_grant updates on every grant.
- SERVE_x: hold the grant until pmem_resp=1.
  - In that cycle, assert x_pmem_resp=1 (combinational from pmem_resp while in SERVE_x) and go to IDLE.
  - The other client's resp stays 0 throughout.
- Turnaround: one IDLE cycle after every completion.
  - Minimum latency is request-to-strobe = 1 cycle (the IDLE decision cycle) plus the pmem latency.
  - Back-to-back transactions are separated by at least 1 idle cycle.
- Read data: i_pmem_rdata and d_pmem_rdata are both driven from pmem_rdata at all times; only the resp qualifies them.
- A pmem_resp arriving in IDLE is ignored: no client resp, no state change.
- Write-back-then-fill sequences from the D-cache are two independent transactions and are re-arbitrated. The I-cache may be served between them.
- conflicts:
  - +1 on each IDLE cycle in which both clients request and a grant is issued.
  - Saturates at 16'hFFFF.
  - Cleared by reset or reset_conflicts; reset_conflicts takes precedence over an increment in the same cycle.
- reset:
  - Next state is IDLE, last_grant=I, conflicts=0.
  - Strobes deassert the cycle after reset is sampled, even mid-transaction. No resp is issued for an aborted transaction.
- No combinational path from client inputs to the state register other than via the IDLE grant decision.

Test Plan:
- D-cache read only, address 16'h0120, pmem_resp after 3 cycles
  -> pmem_read=1 with address 16'h0120 from cycle 1; d_pmem_resp=1 for exactly 1 cycle with pmem_rdata; i_pmem_resp stays 0.
- I read and D write requested in the same cycle after reset
  -> D served first (last_grant=I); I served after 1 IDLE cycle; conflicts=1.
- Both clients requesting continuously for 4 transactions
  -> grants alternate D,I,D,I; conflicts=4.
- Spurious pmem_resp=1 in IDLE
  -> no client resp, state remains IDLE.
- reset asserted during SERVE_I while pmem_read=1
  -> pmem_read=0 next cycle, i_pmem_resp never asserted, conflicts=0.
- Force conflicts to 16'hFFFE, then 3 contested grants
  -> value saturates at 16'hFFFF.
- reset_conflicts coincident with a contested grant
  -> conflicts=0.
